// File: rtl/int_pkg.sv
// int_pkg: shared types and constants for the interrupt controller
package int_pkg;

    typedef enum logic {IDLE, SERVICE} state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0004;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0008;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: fixed-priority encoder, lowest set index wins
module int_prio_enc
    import int_pkg::*;
#(
    parameter int N = 4,
    parameter int W = id_w(N)
) (
    input  logic [N-1:0] vec_i,
    output logic         valid_o,
    output logic [W-1:0] id_o
);

    assign valid_o = |vec_i;

    // scan from the top so the last hit is the lowest index
    always_comb begin
        id_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) id_o = W'(i);
    end

endmodule

// File: rtl/arm_int_ctrl.sv
// arm_int_ctrl: edge-captured, masked, fixed-priority non-nesting interrupt redirect of the PC
module arm_int_ctrl
    import int_pkg::*;
#(
    parameter int               N_SRC      = 4,
    parameter logic [31:0]      VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0]      VEC_STRIDE = DEF_VEC_STRIDE,
    parameter logic [N_SRC-1:0] RESET_MASK = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        irq,
    input  logic                    eret,
    input  logic [31:0]             pc_next,
    input  logic                    mask_we,
    input  logic [N_SRC-1:0]        mask_wdata,
    output logic [31:0]             pc,
    output logic                    int_taken,
    output logic                    in_service,
    output logic [id_w(N_SRC)-1:0]  active_id,
    output logic [N_SRC-1:0]        pending,
    output logic [N_SRC-1:0]        mask
);

    localparam int ID_W = id_w(N_SRC);

    state_e            state_q, state_d;
    logic [N_SRC-1:0]  irq_q, pending_q, pending_d, mask_q, mask_d, rise, eligible;
    logic [31:0]       epc_q, epc_d;
    logic [ID_W-1:0]   active_id_q, active_id_d, sel;
    logic              sel_v, take;

    assign rise     = irq & ~irq_q;
    assign eligible = pending_q & mask_q;

    int_prio_enc #(.N(N_SRC), .W(ID_W)) u_enc (
        .vec_i   (eligible),
        .valid_o (sel_v),
        .id_o    (sel)
    );

    // take decision, PC steering and next-state; eret beats a take, a new edge beats the clear
    always_comb begin
        take        = !reset && !eret && state_q == IDLE && sel_v;
        pc          = (!reset && eret) ? epc_q : take ? VEC_BASE + 32'(sel) * VEC_STRIDE : pc_next;
        state_d     = take ? SERVICE : (state_q == SERVICE && eret) ? IDLE : state_q;
        pending_d   = (pending_q & ~(take ? N_SRC'(1) << sel : '0)) | rise;
        mask_d      = mask_we ? mask_wdata : mask_q;
        epc_d       = take ? pc_next : epc_q;
        active_id_d = take ? sel : active_id_q;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            irq_q       <= '0;
            pending_q   <= '0;
            mask_q      <= RESET_MASK;
            epc_q       <= '0;
            active_id_q <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            epc_q       <= epc_d;
            active_id_q <= active_id_d;
        end
    end

    assign int_taken  = take;
    assign in_service = state_q == SERVICE;
    assign active_id  = active_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_arm_int_ctrl.sv
// tb_arm_int_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_arm_int_ctrl;

    logic        clk = 1'b0;
    logic        reset, eret, mask_we;
    logic [3:0]  irq, mask_wdata;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        int_taken, in_service;
    logic [1:0]  active_id;
    logic [3:0]  pending, mask;

    int vecs = 0;
    int errs = 0;

    logic [3:0]  m_pend, m_mask, m_prev;
    logic        m_srv;
    logic [1:0]  m_id;
    logic [31:0] m_epc;

    arm_int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .eret       (eret),
        .pc_next    (pc_next),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .pc         (pc),
        .int_taken  (int_taken),
        .in_service (in_service),
        .active_id  (active_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    function automatic int m_sel();
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    function automatic logic m_take();
        return !reset && !eret && !m_srv && m_sel() >= 0;
    endfunction

    function automatic logic [31:0] m_pc();
        if (reset) return pc_next;
        if (eret) return m_epc;
        if (m_take()) return 32'h4 + 32'(m_sel()) * 32'h8;
        return pc_next;
    endfunction

    task automatic tick();
        int s;
        @(posedge clk);
        s = m_sel();
        if (reset) begin
            m_pend = 0; m_mask = 4'hF; m_prev = 0; m_srv = 0; m_id = 0; m_epc = 0;
        end else begin
            if (m_take()) begin
                m_epc = pc_next; m_id = 2'(s); m_pend[s] = 1'b0; m_srv = 1'b1;
            end else if (m_srv && eret) m_srv = 1'b0;
            m_pend = m_pend | (irq & ~m_prev);
            m_prev = irq;
            if (mask_we) m_mask = mask_wdata;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; eret = 0; mask_we = 0; mask_wdata = 0; irq = 0; pc_next = 32'h100;
        tick(); tick();
        irq = 4'hF; #1;
        vecs++; if (int_taken !== 1'b0) begin errs++; $display("FAIL rst_take: got %b want 0", int_taken); end
        vecs++; if (pc !== 32'h100) begin errs++; $display("FAIL rst_pc_during: got %h want 100", pc); end
        irq = 0; tick();
        reset = 0; #1;
        vecs++; if (pc !== 32'h100) begin errs++; $display("FAIL rst_pc: got %h want 100", pc); end
        vecs++; if (pending !== 4'h0) begin errs++; $display("FAIL rst_pending: got %h want 0", pending); end
        vecs++; if (mask !== 4'hF) begin errs++; $display("FAIL rst_mask: got %h want f", mask); end
        vecs++; if (in_service !== 1'b0) begin errs++; $display("FAIL rst_insvc: got %b want 0", in_service); end
        vecs++; if (active_id !== 2'd0) begin errs++; $display("FAIL rst_id: got %0d want 0", active_id); end
        tick();
    endtask

    task automatic test_single();
        irq = 4'b0100; pc_next = 32'h40; #1;
        tick();
        irq = 0; #1;
        vecs++; if (int_taken !== 1'b1) begin errs++; $display("FAIL single_take: got %b want 1", int_taken); end
        vecs++; if (pc !== 32'h14) begin errs++; $display("FAIL single_vec: got %h want 14", pc); end
        tick();
        pc_next = 32'h44; #1;
        vecs++; if (in_service !== 1'b1) begin errs++; $display("FAIL single_insvc: got %b want 1", in_service); end
        vecs++; if (active_id !== 2'd2) begin errs++; $display("FAIL single_id: got %0d want 2", active_id); end
        vecs++; if (pending !== 4'h0) begin errs++; $display("FAIL single_clr: got %h want 0", pending); end
        vecs++; if (pc !== 32'h44) begin errs++; $display("FAIL single_seq: got %h want 44", pc); end
        eret = 1; #1;
        vecs++; if (pc !== 32'h40) begin errs++; $display("FAIL single_eret: got %h want 40", pc); end
        tick();
        eret = 0; #1;
        vecs++; if (in_service !== 1'b0) begin errs++; $display("FAIL single_idle: got %b want 0", in_service); end
        tick();
    endtask

    task automatic test_priority();
        irq = 4'b1010; pc_next = 32'h200; #1;
        tick();
        irq = 0; #1;
        vecs++; if (pc !== 32'h0C || int_taken !== 1'b1) begin errs++; $display("FAIL prio_first: got pc %h take %b want 0c 1", pc, int_taken); end
        tick();
        vecs++; if (pending !== 4'b1000) begin errs++; $display("FAIL prio_pend: got %b want 1000", pending); end
        vecs++; if (int_taken !== 1'b0) begin errs++; $display("FAIL prio_nonest: got %b want 0", int_taken); end
        eret = 1; #1;
        tick();
        eret = 0; #1;
        vecs++; if (pc !== 32'h1C || int_taken !== 1'b1) begin errs++; $display("FAIL prio_chain: got pc %h take %b want 1c 1", pc, int_taken); end
        tick();
        eret = 1; #1; tick();
        eret = 0; #1;
    endtask

    task automatic test_mask();
        mask_we = 1; mask_wdata = 4'b1110; #1;
        tick();
        mask_we = 0; irq = 4'b0001; #1;
        vecs++; if (mask !== 4'b1110) begin errs++; $display("FAIL mask_wr: got %b want 1110", mask); end
        tick();
        irq = 0; #1;
        vecs++; if (int_taken !== 1'b0 || pending !== 4'b0001) begin errs++; $display("FAIL mask_hold: got take %b pend %b want 0 0001", int_taken, pending); end
        mask_we = 1; mask_wdata = 4'hF; #1;
        vecs++; if (int_taken !== 1'b0) begin errs++; $display("FAIL mask_early: got %b want 0", int_taken); end
        tick();
        mask_we = 0; #1;
        vecs++; if (int_taken !== 1'b1 || pc !== 32'h04) begin errs++; $display("FAIL mask_take: got take %b pc %h want 1 04", int_taken, pc); end
        tick();
        eret = 1; #1; tick();
        eret = 0; #1;
    endtask

    task automatic test_eret_vs_take();
        irq = 4'b0010; pc_next = 32'h300; #1;
        tick();
        irq = 0; eret = 1; #1;
        vecs++; if (int_taken !== 1'b0 || pc !== m_epc) begin errs++; $display("FAIL eret_wins: got take %b pc %h want 0 %h", int_taken, pc, m_epc); end
        tick();
        eret = 0; #1;
        vecs++; if (int_taken !== 1'b1 || pc !== 32'h0C) begin errs++; $display("FAIL eret_after: got take %b pc %h want 1 0c", int_taken, pc); end
        tick();
        eret = 1; #1; tick();
        eret = 0; #1;
    endtask

    task automatic test_reset_mid();
        irq = 4'b0001; pc_next = 32'h500; #1;
        tick();
        irq = 0; #1; tick();
        irq = 4'b0100; #1; tick();
        irq = 0; #1;
        vecs++; if (in_service !== 1'b1 || pending !== 4'b0100) begin errs++; $display("FAIL mid_setup: got svc %b pend %b want 1 0100", in_service, pending); end
        reset = 1; #1;
        vecs++; if (int_taken !== 1'b0 || pc !== 32'h500) begin errs++; $display("FAIL mid_rst_comb: got take %b pc %h want 0 500", int_taken, pc); end
        tick();
        vecs++; if (in_service !== 1'b0 || pending !== 4'h0 || active_id !== 2'd0 || mask !== 4'hF || int_taken !== 1'b0)
            begin errs++; $display("FAIL mid_rst_state: got svc %b pend %h id %0d mask %h take %b", in_service, pending, active_id, mask, int_taken); end
        reset = 0; eret = 1; #1;
        vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL mid_epc: got %h want 0", pc); end
        tick();
        eret = 0; #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            irq        = irq ^ (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
            eret       = $urandom_range(0, 5) == 0;
            mask_we    = $urandom_range(0, 9) == 0;
            mask_wdata = 4'($urandom);
            pc_next    = $urandom;
            reset      = $urandom_range(0, 99) == 0;
            #1;
            vecs++; if (pc !== m_pc()) begin errs++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc()); end
            vecs++; if (int_taken !== m_take()) begin errs++; $display("FAIL rnd_take[%0d]: got %b want %b", n, int_taken, m_take()); end
            vecs++; if (in_service !== m_srv) begin errs++; $display("FAIL rnd_svc[%0d]: got %b want %b", n, in_service, m_srv); end
            vecs++; if (active_id !== m_id) begin errs++; $display("FAIL rnd_id[%0d]: got %0d want %0d", n, active_id, m_id); end
            vecs++; if (pending !== m_pend) begin errs++; $display("FAIL rnd_pend[%0d]: got %b want %b", n, pending, m_pend); end
            vecs++; if (mask !== m_mask) begin errs++; $display("FAIL rnd_mask[%0d]: got %b want %b", n, mask, m_mask); end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_eret_vs_take();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/arm_int_ctrl.md
# arm_int_ctrl

Multi-source interrupt controller that sits in front of the CPU's next-PC path and replaces the single-line interrupt redirect. Captures rising edges on `N_SRC` interrupt lines, holds them pending, applies a software-writable enable mask, and selects the highest-priority source. On a take it saves `pc_next` as the exception return address and steers `pc` to a per-source vector; `eret` steers `pc` back to the saved address. Non-nesting: one handler in service at a time.

## Interface
- `N_SRC`, default 4: number of interrupt sources (2..16)
- `VEC_BASE`, default 32'h0000_0004: vector of source 0
- `VEC_STRIDE`, default 32'h0000_0008: vector spacing per source index
- `RESET_MASK`, default all ones: mask value after reset (1 = enabled)
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `irq`  in  N_SRC  level inputs, synchronous to `clk`; rising edge = request
- `eret`  in  1  return-from-exception instruction in this cycle
- `pc_next`  in  32  sequential/branch next PC from datapath
- `mask_we`  in  1  write enable for mask register
- `mask_wdata`  in  N_SRC  new mask value
- `pc`  out  32  PC to load this cycle (combinational)
- `int_taken`  out  1  combinational pulse: interrupt taken this cycle
- `in_service`  out  1  registered: handler active
- `active_id`  out  clog2(N_SRC)  registered: source being serviced
- `pending`  out  N_SRC  registered pending bits
- `mask`  out  N_SRC  registered mask

## Operation
- Edge detect: `irq_q <= irq`; `edge = irq & ~irq_q`. Rising edge sets `pending[i]`.
- `eligible = pending & mask`; priority fixed, lowest index highest.
- State IDLE:
  - `eret` = 1: `pc = epc`; no take this cycle; stay IDLE (eret wins over take).
  - else `eligible != 0`: `int_taken = 1`; `pc = VEC_BASE + id*VEC_STRIDE` (32-bit, wraps mod 2^32); next edge: `epc <= pc_next`, `active_id <= id`, `pending[id] <= 0`, state -> SERVICE.
  - else `pc = pc_next`.
- State SERVICE: no new takes; edges keep accumulating in `pending`.
  - `eret` = 1: `pc = epc`; state -> IDLE.
  - else `pc = pc_next`.
- Pending clear vs. new edge on same source, same cycle: new edge wins, bit stays 1.
- Masked pending bits are retained; taken once unmasked.
- Mask write: `mask <= mask_wdata` on the edge after `mask_we`; affects eligibility from the next cycle.
- Reset values: state IDLE, `epc` = 0, `pending` = 0, `irq_q` = 0, `mask` = RESET_MASK, `in_service` = 0, `active_id` = 0. During reset `pc = pc_next`, `int_taken` = 0.

## Timing
- Edge on `irq[i]` sampled at edge t -> `pending[i]` = 1 in cycle t+1 -> if IDLE and enabled, `int_taken` and vector `pc` in cycle t+1.
- `in_service` rises one cycle after `int_taken`; falls the cycle after `eret`.
- Tail chaining: cycle after `eret` is IDLE and may take the next pending source.
- Level held high does not re-request; must drop and rise again.
- Reset mid-service: all state returns to reset values, pending requests lost, `epc` cleared.

## Structure
- Package `int_pkg`: state enum {IDLE, SERVICE}, `ID_W = $clog2(N_SRC)` helper, default `VEC_BASE`/`VEC_STRIDE` constants.
- One sub-module: `int_prio_enc` (N_SRC-bit vector -> `valid`, lowest-set index). Rest is flat in `arm_int_ctrl`.

## Test plan
- Reset, `pc_next` = 32'h100, no irq -> `pc` = 32'h100, `pending` = 0, `mask` = 4'hF, `in_service` = 0.
- Pulse `irq[2]` with `pc_next` = 32'h40 -> next cycle `int_taken` = 1, `pc` = 32'h14; following cycle `in_service` = 1, `active_id` = 2; later `eret` -> `pc` = 32'h40.
- `irq[3]` and `irq[1]` rise same cycle -> source 1 taken (`pc` = 32'h0C), `pending` = 4'b1000; `eret` -> next cycle source 3 taken (`pc` = 32'h1C).
- `mask` = 4'b1110, pulse `irq[0]` -> no take, `pending[0]` = 1; write mask 4'hF -> taken next cycle, `pc` = 32'h04.
- IDLE with `eret` = 1 and `eligible` != 0 same cycle -> `pc` = epc, `int_taken` = 0; take occurs next cycle.
- Assert `reset` while `in_service` = 1 with `pending` = 4'b0100 -> next cycle all outputs at reset values, no take.
